factorial_inverse_seq: RTL and testbench

//   Sequential inverse of the combinational factorial block: given a 16-bit value V,

---
 rtl/factorial_inverse_seq_if.sv | 24 ++
 rtl/factorial_inverse_seq.sv | 92 +++++++++
 tb/tb_factorial_inverse_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/factorial_inverse_seq_if.sv
// Request/result bus of the sequential inverse-factorial block:
// start/value in, busy/done handshake and the decoded result out.
interface factorial_inverse_seq_if #(
    parameter int W  = 16,
    parameter int NW = 4
);
    logic          start;
    logic [W-1:0]  value;
    logic          busy;
    logic          done;
    logic [NW-1:0] n_out;
    logic          exact;
    logic          invalid;

    modport master (
        output start, value,
        input  busy, done, n_out, exact, invalid
    );

    modport slave (
        input  start, value,
        output busy, done, n_out, exact, invalid
    );
endinterface

// File: rtl/factorial_inverse_seq.sv
// Finds the largest n with n! <= V by building n! one multiply per clock,
// then reports n, whether V is exactly n!, and whether V was zero.
module factorial_inverse_seq #(
    parameter int W  = 16,
    parameter int NW = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    factorial_inverse_seq_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [NW-1:0] K_MAX = '1;

    state_t          state_reg, state_next;
    logic [W-1:0]    v_reg, v_next;
    logic [W-1:0]    acc_reg, acc_next;
    logic [NW-1:0]   k_reg, k_next;
    logic [NW-1:0]   n_reg, n_next;
    logic            exact_reg, exact_next;
    logic            invalid_reg, invalid_next;
    logic            done_reg, done_next;
    logic [NW-1:0]   k_inc;
    logic [W+NW-1:0] prod;

    // Full-width product so an overshoot past V can never wrap back below it.
    assign k_inc = k_reg + NW'(1);
    assign prod  = (W+NW)'(acc_reg) * (W+NW)'(k_inc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            v_reg       <= '0;
            acc_reg     <= W'(1);
            k_reg       <= '0;
            n_reg       <= '0;
            exact_reg   <= 1'b0;
            invalid_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            v_reg       <= v_next;
            acc_reg     <= acc_next;
            k_reg       <= k_next;
            n_reg       <= n_next;
            exact_reg   <= exact_next;
            invalid_reg <= invalid_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        v_next       = v_reg;
        acc_next     = acc_reg;
        k_next       = k_reg;
        n_next       = n_reg;
        exact_next   = exact_reg;
        invalid_next = invalid_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    v_next     = bus.value;
                    acc_next   = W'(1);
                    k_next     = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // acc holds k!; advance while (k+1)! still fits under V.
                if (prod <= (W+NW)'(v_reg) && k_reg != K_MAX) begin
                    acc_next = prod[W-1:0];
                    k_next   = k_inc;
                end else begin
                    n_next       = k_reg;
                    exact_next   = (acc_reg == v_reg);
                    invalid_next = (v_reg == '0);
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy    = (state_reg == RUN);
    assign bus.done    = done_reg;
    assign bus.n_out   = n_reg;
    assign bus.exact   = exact_reg;
    assign bus.invalid = invalid_reg;
endmodule

// File: tb/tb_factorial_inverse_seq.sv
// Self-checking bench for factorial_inverse_seq: directed table, handshake
// corner cases, reset abort, factorial sweep and random values against a model.
module tb_factorial_inverse_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    factorial_inverse_seq_if #(.W(16), .NW(4)) bus ();

    factorial_inverse_seq #(.W(16), .NW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] value;
        int          n;
        int          exact;
        int          invalid;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: grow n while (n+1)! still fits under v, using plain integers.
    task automatic model(input int v, output int n, output int ex, output int inv, output int lat);
        longint f;
        n = 0;
        f = 1;
        if (v == 0) begin
            ex = 0; inv = 1; lat = 1;
        end else begin
            while (f * (n + 1) <= v) begin
                n++;
                f = f * n;
            end
            ex  = (f == v) ? 1 : 0;
            inv = 0;
            lat = n + 1;
        end
    endtask

    function automatic int fact(input int num);
        int f = 1;
        for (int i = 2; i <= num; i++) f = f * i;
        return f;
    endfunction

    // Called #1 after an edge: presents a request and returns #1 after the start edge.
    task automatic launch(input logic [15:0] v);
        bus.start = 1'b1;
        bus.value = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.value = $urandom;
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) return;
        end
        miscompares++;
        vectors++;
        $display("FAIL %s: no done within 40 cycles", name);
        lat = -1;
    endtask

    task automatic run_op(input string name, input logic [15:0] v, input int n,
                          input int ex, input int inv, input int lat);
        int got_lat;
        launch(v);
        wait_done(name, got_lat);
        if (got_lat < 0) return;
        chk({name, " latency"}, got_lat, lat);
        chk({name, " n_out"}, int'(bus.n_out), n);
        chk({name, " exact"}, int'(bus.exact), ex);
        chk({name, " invalid"}, int'(bus.invalid), inv);
        chk({name, " busy in done cycle"}, int'(bus.busy), 0);
        @(posedge clk);
        #1;
        chk({name, " done one cycle"}, int'(bus.done), 0);
    endtask

    initial begin
        int lat, n, ex, inv, dones;
        logic [15:0] v;

        tbl[0] = '{16'd5040,  7, 1, 0, 8};
        tbl[1] = '{16'd5000,  6, 0, 0, 7};
        tbl[2] = '{16'd0,     0, 0, 1, 1};
        tbl[3] = '{16'd1,     1, 1, 0, 2};
        tbl[4] = '{16'd65535, 8, 0, 0, 9};
        tbl[5] = '{16'd40320, 8, 1, 0, 9};
        tbl[6] = '{16'd2,     2, 1, 0, 3};
        tbl[7] = '{16'd6,     3, 1, 0, 4};
        tbl[8] = '{16'd5,     2, 0, 0, 3};

        bus.start = 1'b0;
        bus.value = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset n_out", int'(bus.n_out), 0);
        chk("reset exact", int'(bus.exact), 0);
        chk("reset invalid", int'(bus.invalid), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("table[%0d] v=%0d", i, tbl[i].value), tbl[i].value,
                   tbl[i].n, tbl[i].exact, tbl[i].invalid, tbl[i].lat);
            $display("table v=%0d n_out=%0d exact=%0d invalid=%0d", tbl[i].value,
                     bus.n_out, bus.exact, bus.invalid);
        end

        // Start held through RUN while value changes: captured operand wins, one done only.
        bus.start = 1'b1;
        bus.value = 16'd720;
        @(posedge clk);
        #1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            bus.value = 16'd65535;
            if (i == 3) bus.start = 1'b0;
            if (i < 3) chk("held start busy", int'(bus.busy), 1);
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                chk("held start latency", i + 1, 7);
                chk("held start n_out", int'(bus.n_out), 6);
                chk("held start exact", int'(bus.exact), 1);
            end
        end
        chk("held start done count", dones, 1);
        $display("held start: dones=%0d n_out=%0d", dones, bus.n_out);

        // Back-to-back: start presented in the done cycle.
        launch(16'd24);
        wait_done("b2b first", lat);
        chk("b2b first n_out", int'(bus.n_out), 4);
        launch(16'd120);
        chk("b2b busy after accept", int'(bus.busy), 1);
        wait_done("b2b second", lat);
        chk("b2b second latency", lat, 6);
        chk("b2b second n_out", int'(bus.n_out), 5);
        chk("b2b second exact", int'(bus.exact), 1);
        $display("back-to-back: n_out=%0d exact=%0d", bus.n_out, bus.exact);
        @(posedge clk);
        #1;

        // Reset mid-RUN aborts with no done.
        launch(16'd40320);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort busy", int'(bus.busy), 0);
        chk("abort done", int'(bus.done), 0);
        chk("abort n_out", int'(bus.n_out), 0);
        chk("abort exact", int'(bus.exact), 0);
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("abort no done", dones, 0);
        $display("reset abort: dones=%0d", dones);

        for (int num = 0; num <= 7; num++) begin
            v = 16'(fact(num));
            n = (num < 1) ? 1 : num;
            run_op($sformatf("sweep num=%0d", num), v, n, 1, 0, n + 1);
            $display("sweep num=%0d v=%0d n_out=%0d exact=%0d", num, v, bus.n_out, bus.exact);
        end

        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0: v = 16'($urandom_range(0, 30));
                1: v = 16'(fact($urandom_range(1, 8)) + $urandom_range(0, 2) - 1);
                default: v = 16'($urandom);
            endcase
            model(int'(v), n, ex, inv, lat);
            run_op($sformatf("random v=%0d", v), v, n, ex, inv, lat);
            $display("random v=%0d n_out=%0d exact=%0d invalid=%0d", v, bus.n_out,
                     bus.exact, bus.invalid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
